// File: rtl/sdrc_req_arb.sv
// sdrc_req_arb
// Shares the SDRAM controller application request interface between two
// requesters (port 0 and port 1). Runs entirely in the sdram_clk domain.
// Requests are granted round-robin and write beats are routed to the owner
// of the current write burst. Read data goes back to the issuing port in
// request order, using a small FIFO of port tags.
//
// Ports (N = 0, 1):
//   sdram_clk, sdram_resetn   clock, asynchronous active-low reset
//   pN_req*                   request handshake from requester N
//   pN_wr_next/en_n/data      write-beat handshake and data for requester N
//   pN_rd_valid/last_rd       read return for requester N
//   p_rd_data                 read data shared by both ports
//   sdr_req*                  request handshake to the controller
//   sdr_busy_n                controller ready for new requests
//   sdr_wr_next/en_n/data     write-beat handshake and data to the controller
//   sdr_rd_valid/last_rd/data read return from the controller
//   arb_err                   sticky protocol error flag
module sdrc_req_arb #(
    parameter int dw     = 32,
    parameter int bl     = 9,
    parameter int APP_AW = 26,
    parameter int TAG_DP = 4
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              p0_req,
    input  logic [APP_AW-1:0] p0_req_addr,
    input  logic [bl-1:0]     p0_req_len,
    input  logic              p0_req_wr_n,
    output logic              p0_req_ack,
    output logic              p0_wr_next,
    input  logic [dw/8-1:0]   p0_wr_en_n,
    input  logic [dw-1:0]     p0_wr_data,
    output logic              p0_rd_valid,
    output logic              p0_last_rd,
    input  logic              p1_req,
    input  logic [APP_AW-1:0] p1_req_addr,
    input  logic [bl-1:0]     p1_req_len,
    input  logic              p1_req_wr_n,
    output logic              p1_req_ack,
    output logic              p1_wr_next,
    input  logic [dw/8-1:0]   p1_wr_en_n,
    input  logic [dw-1:0]     p1_wr_data,
    output logic              p1_rd_valid,
    output logic              p1_last_rd,
    output logic [dw-1:0]     p_rd_data,
    output logic              sdr_req,
    output logic [APP_AW-1:0] sdr_req_addr,
    output logic [bl-1:0]     sdr_req_len,
    output logic              sdr_req_wr_n,
    input  logic              sdr_req_ack,
    input  logic              sdr_busy_n,
    input  logic              sdr_wr_next,
    output logic [dw/8-1:0]   sdr_wr_en_n,
    output logic [dw-1:0]     sdr_wr_data,
    input  logic              sdr_rd_valid,
    input  logic              sdr_last_rd,
    input  logic [dw-1:0]     sdr_rd_data,
    output logic              arb_err
);

    localparam int TAG_AW = (TAG_DP > 1) ? $clog2(TAG_DP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WDAT = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sel, w_sel_nxt;
    logic              r_rr_last, w_rr_last_nxt;
    logic              r_wr_owner, w_wr_owner_nxt;
    logic [bl-1:0]     r_cnt, w_cnt_nxt;
    logic [TAG_DP-1:0] r_tag_mem;
    logic [TAG_AW-1:0] r_tag_wp, r_tag_rp;
    logic [TAG_AW:0]   r_tag_occ;
    logic              r_err;

    logic              w_tag_empty, w_tag_full, w_tag_head;
    logic              w_push, w_pop, w_len0_err, w_err_set;
    logic              w_elig0, w_elig1, w_winner;
    logic              w_in_req, w_in_wdat;
    logic [APP_AW-1:0] w_sel_addr;
    logic [bl-1:0]     w_sel_len;
    logic              w_sel_wr_n;

    assign w_in_req    = (r_state == ST_REQ);
    assign w_in_wdat   = (r_state == ST_WDAT);
    assign w_tag_empty = (r_tag_occ == '0);
    assign w_tag_full  = (r_tag_occ >= (TAG_AW+1)'(TAG_DP));
    assign w_tag_head  = r_tag_mem[r_tag_rp];
    assign w_pop       = sdr_rd_valid & sdr_last_rd & ~w_tag_empty;

    // Occupancy is taken before any same-cycle pop, so a read may wait one
    // extra cycle after the FIFO drains from full.
    assign w_elig0  = p0_req & sdr_busy_n & (~p0_req_wr_n | ~w_tag_full);
    assign w_elig1  = p1_req & sdr_busy_n & (~p1_req_wr_n | ~w_tag_full);
    assign w_winner = (w_elig0 & w_elig1) ? ~r_rr_last : w_elig1;

    assign w_sel_addr = r_sel ? p1_req_addr : p0_req_addr;
    assign w_sel_len  = r_sel ? p1_req_len  : p0_req_len;
    assign w_sel_wr_n = r_sel ? p1_req_wr_n : p0_req_wr_n;

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_rr_last_nxt  = r_rr_last;
        w_wr_owner_nxt = r_wr_owner;
        w_cnt_nxt      = r_cnt;
        w_push         = 1'b0;
        w_len0_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_sel_nxt   = w_winner;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdr_req_ack) begin
                    w_rr_last_nxt = r_sel;
                    if (w_sel_wr_n) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_sel_len == '0) begin
                        w_len0_err  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt      = w_sel_len;
                        w_wr_owner_nxt = r_sel;
                        w_state_nxt    = ST_WDAT;
                    end
                end
            end
            ST_WDAT: begin
                if (sdr_wr_next) begin
                    w_cnt_nxt = r_cnt - bl'(1);
                    if (r_cnt == bl'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_err_set = (sdr_rd_valid & w_tag_empty)
                     | (sdr_wr_next & ~w_in_wdat)
                     | (sdr_req_ack & ~w_in_req)
                     | w_len0_err;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_rr_last  <= 1'b1;
            r_wr_owner <= 1'b0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_wr_owner <= w_wr_owner_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_tag_mem <= '0;
            r_tag_wp  <= '0;
            r_tag_rp  <= '0;
            r_tag_occ <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_tag_wp] <= r_sel;
                r_tag_wp            <= r_tag_wp + TAG_AW'(1);
            end
            if (w_pop) begin
                r_tag_rp <= r_tag_rp + TAG_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_tag_occ <= r_tag_occ + (TAG_AW+1)'(1);
                2'b01:   r_tag_occ <= r_tag_occ - (TAG_AW+1)'(1);
                default: r_tag_occ <= r_tag_occ;
            endcase
        end
    end

    assign sdr_req      = w_in_req;
    assign sdr_req_addr = w_in_req ? w_sel_addr : '0;
    assign sdr_req_len  = w_in_req ? w_sel_len  : '0;
    assign sdr_req_wr_n = w_in_req & w_sel_wr_n;
    assign p0_req_ack   = w_in_req & sdr_req_ack & ~r_sel;
    assign p1_req_ack   = w_in_req & sdr_req_ack &  r_sel;

    assign p0_wr_next  = w_in_wdat & sdr_wr_next & ~r_wr_owner;
    assign p1_wr_next  = w_in_wdat & sdr_wr_next &  r_wr_owner;
    assign sdr_wr_data = w_in_wdat ? (r_wr_owner ? p1_wr_data : p0_wr_data) : '0;
    assign sdr_wr_en_n = w_in_wdat ? (r_wr_owner ? p1_wr_en_n : p0_wr_en_n) : '1;

    assign p0_rd_valid = sdr_rd_valid & ~w_tag_empty & ~w_tag_head;
    assign p1_rd_valid = sdr_rd_valid & ~w_tag_empty &  w_tag_head;
    assign p0_last_rd  = sdr_last_rd  & ~w_tag_empty & ~w_tag_head;
    assign p1_last_rd  = sdr_last_rd  & ~w_tag_empty &  w_tag_head;
    assign p_rd_data   = sdr_rd_data;

    assign arb_err = r_err;

endmodule

// File: tb/tb_sdrc_req_arb.sv
module tb_sdrc_req_arb;
    localparam int DW = 32;
    localparam int BL = 9;
    localparam int AW = 26;
    localparam int TD = 4;

    logic sdram_clk = 1'b0;
    logic sdram_resetn;
    logic p0_req, p0_req_wr_n, p0_req_ack, p0_wr_next, p0_rd_valid, p0_last_rd;
    logic [AW-1:0] p0_req_addr;
    logic [BL-1:0] p0_req_len;
    logic [DW/8-1:0] p0_wr_en_n;
    logic [DW-1:0] p0_wr_data;
    logic p1_req, p1_req_wr_n, p1_req_ack, p1_wr_next, p1_rd_valid, p1_last_rd;
    logic [AW-1:0] p1_req_addr;
    logic [BL-1:0] p1_req_len;
    logic [DW/8-1:0] p1_wr_en_n;
    logic [DW-1:0] p1_wr_data;
    logic [DW-1:0] p_rd_data;
    logic sdr_req, sdr_req_wr_n, sdr_req_ack, sdr_busy_n, sdr_wr_next;
    logic [AW-1:0] sdr_req_addr;
    logic [BL-1:0] sdr_req_len;
    logic [DW/8-1:0] sdr_wr_en_n;
    logic [DW-1:0] sdr_wr_data;
    logic sdr_rd_valid, sdr_last_rd, arb_err;
    logic [DW-1:0] sdr_rd_data;

    always #5 sdram_clk = ~sdram_clk;

    sdrc_req_arb #(.dw(DW), .bl(BL), .APP_AW(AW), .TAG_DP(TD)) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
        .p0_req(p0_req), .p0_req_addr(p0_req_addr), .p0_req_len(p0_req_len),
        .p0_req_wr_n(p0_req_wr_n), .p0_req_ack(p0_req_ack), .p0_wr_next(p0_wr_next),
        .p0_wr_en_n(p0_wr_en_n), .p0_wr_data(p0_wr_data),
        .p0_rd_valid(p0_rd_valid), .p0_last_rd(p0_last_rd),
        .p1_req(p1_req), .p1_req_addr(p1_req_addr), .p1_req_len(p1_req_len),
        .p1_req_wr_n(p1_req_wr_n), .p1_req_ack(p1_req_ack), .p1_wr_next(p1_wr_next),
        .p1_wr_en_n(p1_wr_en_n), .p1_wr_data(p1_wr_data),
        .p1_rd_valid(p1_rd_valid), .p1_last_rd(p1_last_rd),
        .p_rd_data(p_rd_data),
        .sdr_req(sdr_req), .sdr_req_addr(sdr_req_addr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_req_ack(sdr_req_ack), .sdr_busy_n(sdr_busy_n),
        .sdr_wr_next(sdr_wr_next), .sdr_wr_en_n(sdr_wr_en_n), .sdr_wr_data(sdr_wr_data),
        .sdr_rd_valid(sdr_rd_valid), .sdr_last_rd(sdr_last_rd), .sdr_rd_data(sdr_rd_data),
        .arb_err(arb_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [AW-1:0] addr_of(input int p);
        return (p == 1) ? p1_req_addr : p0_req_addr;
    endfunction
    function automatic logic [BL-1:0] len_of(input int p);
        return (p == 1) ? p1_req_len : p0_req_len;
    endfunction
    function automatic logic wr_n_of(input int p);
        return (p == 1) ? p1_req_wr_n : p0_req_wr_n;
    endfunction
    function automatic logic [DW-1:0] data_of(input int p);
        return (p == 1) ? p1_wr_data : p0_wr_data;
    endfunction
    function automatic logic [DW/8-1:0] en_of(input int p);
        return (p == 1) ? p1_wr_en_n : p0_wr_en_n;
    endfunction

    // Behavioural model: who is being offered to the controller (m_grant),
    // who owns the write burst and how many beats remain, and the queue of
    // ports awaiting read data. -1 means nobody.
    int m_grant, m_writer, m_beats, m_last, m_occ;
    bit m_err, m_e0, m_e1;
    int m_tags[$];

    always @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            m_grant = -1; m_writer = -1; m_beats = 0; m_last = 1; m_err = 0;
            m_tags.delete();
        end else begin
            m_occ = m_tags.size();
            if (sdr_rd_valid && m_occ == 0) m_err = 1;
            if (sdr_wr_next && m_writer < 0) m_err = 1;
            if (sdr_req_ack && m_grant < 0) m_err = 1;
            if (sdr_rd_valid && sdr_last_rd && m_occ > 0) m_tags.delete(0);
            if (m_grant >= 0) begin
                if (sdr_req_ack) begin
                    m_last = m_grant;
                    if (wr_n_of(m_grant)) m_tags.push_back(m_grant);
                    else if (len_of(m_grant) == 0) m_err = 1;
                    else begin
                        m_writer = m_grant;
                        m_beats  = int'(len_of(m_grant));
                    end
                    m_grant = -1;
                end
            end else if (m_writer >= 0) begin
                if (sdr_wr_next) begin
                    m_beats--;
                    if (m_beats == 0) m_writer = -1;
                end
            end else begin
                m_e0 = p0_req && sdr_busy_n && (!p0_req_wr_n || m_occ < TD);
                m_e1 = p1_req && sdr_busy_n && (!p1_req_wr_n || m_occ < TD);
                if (m_e0 && m_e1) m_grant = (m_last == 0) ? 1 : 0;
                else if (m_e0) m_grant = 0;
                else if (m_e1) m_grant = 1;
            end
        end
    end

    bit hd0, hd1;
    always @(negedge sdram_clk) begin
        hd0 = (m_tags.size() > 0) && (m_tags[0] == 0);
        hd1 = (m_tags.size() > 0) && (m_tags[0] == 1);
        chk("sdr_req", sdr_req, m_grant >= 0);
        chk("sdr_req_addr", sdr_req_addr, (m_grant < 0) ? '0 : addr_of(m_grant));
        chk("sdr_req_len", sdr_req_len, (m_grant < 0) ? '0 : len_of(m_grant));
        chk("sdr_req_wr_n", sdr_req_wr_n, (m_grant < 0) ? 1'b0 : wr_n_of(m_grant));
        chk("p0_req_ack", p0_req_ack, (m_grant == 0) && sdr_req_ack);
        chk("p1_req_ack", p1_req_ack, (m_grant == 1) && sdr_req_ack);
        chk("p0_wr_next", p0_wr_next, (m_writer == 0) && sdr_wr_next);
        chk("p1_wr_next", p1_wr_next, (m_writer == 1) && sdr_wr_next);
        chk("sdr_wr_data", sdr_wr_data, (m_writer < 0) ? '0 : data_of(m_writer));
        chk("sdr_wr_en_n", sdr_wr_en_n, (m_writer < 0) ? 4'hf : en_of(m_writer));
        chk("p0_rd_valid", p0_rd_valid, hd0 && sdr_rd_valid);
        chk("p0_last_rd", p0_last_rd, hd0 && sdr_last_rd);
        chk("p1_rd_valid", p1_rd_valid, hd1 && sdr_rd_valid);
        chk("p1_last_rd", p1_last_rd, hd1 && sdr_last_rd);
        chk("p_rd_data", p_rd_data, sdr_rd_data);
        chk("arb_err", arb_err, m_err);
    end

    // Event counters used by the hand-computed expectations.
    int cnt_wn0, cnt_wn1, cnt_req_hi;
    int g_order[$];
    int r_order[$];
    always @(negedge sdram_clk) begin
        if (p0_wr_next) cnt_wn0++;
        if (p1_wr_next) cnt_wn1++;
        if (sdr_req) cnt_req_hi++;
        if (p0_req_ack) g_order.push_back(0);
        if (p1_req_ack) g_order.push_back(1);
        if (p0_rd_valid) r_order.push_back(0);
        if (p1_rd_valid) r_order.push_back(1);
    end

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic clr_inputs();
        p0_req = 0; p0_req_addr = '0; p0_req_len = '0; p0_req_wr_n = 0;
        p0_wr_en_n = '1; p0_wr_data = '0;
        p1_req = 0; p1_req_addr = '0; p1_req_len = '0; p1_req_wr_n = 0;
        p1_wr_en_n = '1; p1_wr_data = '0;
        sdr_req_ack = 0; sdr_busy_n = 1; sdr_wr_next = 0;
        sdr_rd_valid = 0; sdr_last_rd = 0; sdr_rd_data = '0;
    endtask

    task automatic do_reset();
        sdram_resetn = 0;
        clr_inputs();
        tick();
        tick();
        sdram_resetn = 1;
        tick();
    endtask

    task automatic set_port(input int p, input logic rq, input logic [AW-1:0] a,
                            input logic [BL-1:0] l, input logic wn);
        if (p == 0) begin
            p0_req = rq; p0_req_addr = a; p0_req_len = l; p0_req_wr_n = wn;
        end else begin
            p1_req = rq; p1_req_addr = a; p1_req_len = l; p1_req_wr_n = wn;
        end
    endtask

    task automatic wait_sdr_req();
        for (int i = 0; i < 40 && !sdr_req; i++) tick();
        chk("wait_sdr_req", sdr_req, 1'b1);
    endtask

    task automatic grant(input int p, input logic [AW-1:0] a, input logic [BL-1:0] l,
                         input logic wn);
        set_port(p, 1'b1, a, l, wn);
        wait_sdr_req();
        sdr_req_ack = 1;
        tick();
        sdr_req_ack = 0;
        if (p == 0) p0_req = 0; else p1_req = 0;
    endtask

    task automatic wburst(input int p, input int n, input logic [DW-1:0] base, input bit gaps);
        for (int b = 0; b < n; b++) begin
            if (p == 0) begin p0_wr_data = base + DW'(b); p0_wr_en_n = 4'(b); end
            else begin p1_wr_data = base + DW'(b); p1_wr_en_n = 4'(b); end
            sdr_wr_next = 1;
            tick();
            sdr_wr_next = 0;
            if (gaps && (b % 2 == 1)) tick();
        end
    endtask

    task automatic ret_beat(input logic last, input logic [DW-1:0] d);
        sdr_rd_valid = 1; sdr_last_rd = last; sdr_rd_data = d;
        tick();
        sdr_rd_valid = 0; sdr_last_rd = 0; sdr_rd_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        sdram_resetn = 0;
        clr_inputs();
        tick();
        @(negedge sdram_clk);
        chk("rst_sdr_req", sdr_req, 1'b0);
        chk("rst_wr_en_n", sdr_wr_en_n, 4'hf);
        chk("rst_arb_err", arb_err, 1'b0);
        tick();
        sdram_resetn = 1;
        tick();

        // Contention: both ports hold reads from reset.
        g_order.delete();
        set_port(0, 1'b1, 26'h10, 9'd1, 1'b1);
        set_port(1, 1'b1, 26'h20, 9'd1, 1'b1);
        for (int g = 0; g < 4; g++) begin
            wait_sdr_req();
            sdr_req_ack = 1;
            tick();
            sdr_req_ack = 0;
        end
        p0_req = 0; p1_req = 0;
        tick();
        chk("grant_count", g_order.size(), 4);
        for (int g = 0; g < 4 && g < g_order.size(); g++)
            chk("grant_order", g_order[g], exp_order[g]);
        r_order.delete();
        for (int g = 0; g < 4; g++) ret_beat(1'b1, 32'h1000 + DW'(g));
        tick();
        chk("ret_count", r_order.size(), 4);
        for (int g = 0; g < 4 && g < r_order.size(); g++)
            chk("ret_order", r_order[g], exp_order[g]);

        // Single write, len 4.
        cnt_wn0 = 0; cnt_wn1 = 0;
        set_port(0, 1'b1, 26'h100, 9'd4, 1'b0);
        @(negedge sdram_clk);
        chk("lat_before", sdr_req, 1'b0);
        tick();
        chk("lat_after", sdr_req, 1'b1);
        chk("wr_addr", sdr_req_addr, 26'h100);
        sdr_req_ack = 1;
        tick();
        sdr_req_ack = 0; p0_req = 0;
        wburst(0, 4, 32'hA000_0000, 1'b1);
        tick();
        chk("p0_wr_next_cnt", cnt_wn0, 4);
        chk("p1_wr_next_cnt", cnt_wn1, 0);
        chk("idle_wr_en_n", sdr_wr_en_n, 4'hf);

        // In-order reads: p1 len 2, then p0 len 1.
        grant(1, 26'h200, 9'd2, 1'b1);
        grant(0, 26'h300, 9'd1, 1'b1);
        sdr_rd_valid = 1; sdr_last_rd = 0; sdr_rd_data = 32'hD0;
        @(negedge sdram_clk);
        chk("d0_p1_valid", p1_rd_valid, 1'b1);
        chk("d0_p1_last", p1_last_rd, 1'b0);
        chk("d0_data", p_rd_data, 32'hD0);
        tick();
        sdr_last_rd = 1; sdr_rd_data = 32'hD1;
        @(negedge sdram_clk);
        chk("d1_p1_valid", p1_rd_valid, 1'b1);
        chk("d1_p1_last", p1_last_rd, 1'b1);
        tick();
        sdr_rd_data = 32'hD2;
        @(negedge sdram_clk);
        chk("d2_p0_valid", p0_rd_valid, 1'b1);
        chk("d2_p0_last", p0_last_rd, 1'b1);
        chk("d2_p1_valid", p1_rd_valid, 1'b0);
        tick();
        sdr_rd_valid = 0; sdr_last_rd = 0; sdr_rd_data = '0;
        tick();

        // Tag FIFO full.
        for (int g = 0; g < 4; g++) grant(0, 26'h400 + AW'(g), 9'd1, 1'b1);
        set_port(0, 1'b1, 26'h410, 9'd1, 1'b1);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("full_blocks", sdr_req, 1'b0);
        end
        ret_beat(1'b1, 32'h55);
        tick();
        chk("full_regrant", sdr_req, 1'b1);
        chk("full_regrant_addr", sdr_req_addr, 26'h410);
        sdr_req_ack = 1;
        tick();
        sdr_req_ack = 0; p0_req = 0;
        for (int g = 0; g < 4; g++) ret_beat(1'b1, 32'h60 + DW'(g));
        tick();

        // Busy controller, then a read held off by a write burst.
        sdr_busy_n = 0;
        cnt_req_hi = 0;
        set_port(1, 1'b1, 26'h600, 9'd1, 1'b1);
        repeat (4) tick();
        chk("busy_no_req", cnt_req_hi, 0);
        p1_req = 0; sdr_busy_n = 1;
        tick();
        grant(0, 26'h500, 9'd8, 1'b0);
        set_port(1, 1'b1, 26'h600, 9'd1, 1'b1);
        cnt_req_hi = 0;
        wburst(0, 8, 32'hB000_0000, 1'b0);
        chk("wdat_no_req", cnt_req_hi, 0);
        tick();
        chk("after_burst_req", sdr_req, 1'b1);
        chk("after_burst_addr", sdr_req_addr, 26'h600);
        sdr_req_ack = 1;
        tick();
        sdr_req_ack = 0; p1_req = 0;
        ret_beat(1'b1, 32'h77);
        tick();

        // Error conditions.
        chk("err_clear", arb_err, 1'b0);
        ret_beat(1'b0, 32'h88);
        chk("err_rd_empty", arb_err, 1'b1);
        repeat (3) tick();
        chk("err_sticky", arb_err, 1'b1);
        do_reset();
        chk("err_after_rst", arb_err, 1'b0);
        sdr_wr_next = 1; tick(); sdr_wr_next = 0;
        chk("err_wr_next", arb_err, 1'b1);
        do_reset();
        sdr_req_ack = 1; tick(); sdr_req_ack = 0;
        chk("err_ack_idle", arb_err, 1'b1);
        do_reset();
        grant(0, 26'h700, 9'd0, 1'b0);
        chk("err_len0", arb_err, 1'b1);
        tick();
        chk("len0_idle", sdr_wr_en_n, 4'hf);

        // Asynchronous reset in the middle of a write burst.
        do_reset();
        grant(0, 26'h800, 9'd4, 1'b0);
        wburst(0, 1, 32'hC000_0000, 1'b0);
        sdr_rd_valid = 1; sdr_wr_next = 1; p0_wr_data = 32'hC0DE; p0_wr_en_n = 4'h5;
        tick();
        sdr_rd_valid = 0;
        chk("pre_rst_err", arb_err, 1'b1);
        chk("pre_rst_wr_next", p0_wr_next, 1'b1);
        chk("pre_rst_wr_data", sdr_wr_data, 32'hC0DE);
        #2;
        sdram_resetn = 0;
        #1;
        chk("arst_wr_next", p0_wr_next, 1'b0);
        chk("arst_wr_en_n", sdr_wr_en_n, 4'hf);
        chk("arst_wr_data", sdr_wr_data, 32'h0);
        chk("arst_sdr_req", sdr_req, 1'b0);
        chk("arst_arb_err", arb_err, 1'b0);
        clr_inputs();
        tick();
        tick();
        sdram_resetn = 1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
